// File: rtl/gate_check_pkg.sv
// Shared definitions for the basic-gate response checker: gate bit positions,
// FSM states and the golden truth function reused by benches.
package gate_check_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XNOR = 5;
  localparam int NUM_GATES = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [NUM_GATES-1:0] golden_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g            = 6'b000000;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_XOR]  = a ^ b;
    g[GATE_NAND] = ~(a & b);
    g[GATE_NOR]  = ~(a | b);
    g[GATE_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational golden reference: maps a {a,b} stimulus to the six expected
// gate outputs, kept separate so it can be checked without the FSM.
module gate_golden_model
  import gate_check_pkg::*;
(
  input  logic [1:0]           in_vec,
  output logic [NUM_GATES-1:0] exp
);

  assign exp = golden_gates(in_vec[1], in_vec[0]);

endmodule

// File: rtl/gate_response_checker.sv
// Response-side checker for the two-input gate blocks: compares each accepted
// beat against golden values, tracks vector order and latches the first failure.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_vec,
  input  logic [NUM_GATES-1:0] in_resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic                 order_err,
  output logic                 first_fail_valid,
  output logic [1:0]           first_fail_vec,
  output logic [NUM_GATES-1:0] first_fail_mask
);

  localparam int BEAT_W = $clog2(NUM_VECTORS + 1);

  state_t               state;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [1:0]           seq_exp;
  logic [NUM_GATES-1:0] exp;
  logic [NUM_GATES-1:0] mask;
  logic                 mismatch;
  logic                 accept;
  logic                 last_beat;

  gate_golden_model u_golden (
    .in_vec (in_vec),
    .exp    (exp)
  );

  assign mask      = in_resp ^ exp;
  assign mismatch  = |mask;
  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_cnt == BEAT_W'(NUM_VECTORS - 1));
  assign pass      = done & (err_count == {CNT_W{1'b0}}) & ~order_err;

  // Run-control FSM; statistics update on the accepting edge so the final
  // beat's result is visible together with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      in_ready         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_count        <= {CNT_W{1'b0}};
      order_err        <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 2'b00;
      first_fail_mask  <= 6'b000000;
      beat_cnt         <= {BEAT_W{1'b0}};
      seq_exp          <= 2'b00;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state            <= S_RUN;
            in_ready         <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            err_count        <= {CNT_W{1'b0}};
            order_err        <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'b00;
            first_fail_mask  <= 6'b000000;
            beat_cnt         <= {BEAT_W{1'b0}};
            seq_exp          <= 2'b00;
          end
        end
        S_RUN: begin
          if (accept) begin
            seq_exp <= seq_exp + 2'd1;
            if (in_vec != seq_exp) begin
              order_err <= 1'b1;
            end
            if (mismatch) begin
              if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
              end
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= in_vec;
                first_fail_mask  <= mask;
              end
            end
            if (last_beat) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              beat_cnt <= {BEAT_W{1'b0}};
            end else begin
              beat_cnt <= beat_cnt + {{(BEAT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench: directed and randomized runs compared against a
// queue-based model of the accepted beats.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       reset, start_a, start_b, in_valid;
  logic [1:0] in_vec;
  logic [5:0] in_resp;

  logic       rdy_a, busy_a, done_a, pass_a, ord_a, ffv_a;
  logic [7:0] errc_a;
  logic [1:0] ffvec_a;
  logic [5:0] ffmask_a;

  logic       rdy_b, busy_b, done_b, pass_b, ord_b, ffv_b;
  logic [1:0] errc_b;
  logic [1:0] ffvec_b;
  logic [5:0] ffmask_b;

  int checks   = 0;
  int failures = 0;

  logic [1:0] q_vec[$];
  logic [5:0] q_resp[$];

  always #5 clk = ~clk;

  gate_response_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
    .in_vec(in_vec), .in_resp(in_resp), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(errc_a), .order_err(ord_a), .first_fail_valid(ffv_a),
    .first_fail_vec(ffvec_a), .first_fail_mask(ffmask_a)
  );

  gate_response_checker #(.NUM_VECTORS(6), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
    .in_vec(in_vec), .in_resp(in_resp), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(errc_b), .order_err(ord_b), .first_fail_valid(ffv_b),
    .first_fail_vec(ffvec_b), .first_fail_mask(ffmask_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Truth-table reference built from arithmetic on the two input bits.
  function automatic logic [5:0] ref_exp(input logic [1:0] v);
    int a, b, s, r;
    a = int'(v[1]);
    b = int'(v[0]);
    s = a + b;
    r = 0;
    if (a * b == 1) r += 1;
    if (s > 0)      r += 2;
    if (s == 1)     r += 4;
    if (a * b == 0) r += 8;
    if (s == 0)     r += 16;
    if (s != 1)     r += 32;
    return 6'(r);
  endfunction

  task automatic start_run(input bit sel_b);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    q_vec.delete();
    q_resp.delete();
    chk("start.busy", sel_b ? busy_b : busy_a, 1);
    chk("start.in_ready", sel_b ? rdy_b : rdy_a, 1);
    chk("start.err_clear", sel_b ? 32'(errc_b) : 32'(errc_a), 0);
  endtask

  task automatic beat(input logic [1:0] v, input logic [5:0] r);
    in_valid = 1'b1;
    in_vec   = v;
    in_resp  = r;
    tick();
    q_vec.push_back(v);
    q_resp.push_back(r);
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_vec   = 2'($urandom_range(0, 3));
    in_resp  = 6'($urandom_range(0, 63));
    tick();
  endtask

  // Derives the end-of-run statistics from the list of accepted beats.
  task automatic check_run(input string tag, input bit sel_b);
    int         n_err, max_cnt;
    bit         m_ffv, m_ord;
    logic [1:0] m_ffvec;
    logic [5:0] m_ffmask, m;
    n_err    = 0;
    m_ffv    = 1'b0;
    m_ord    = 1'b0;
    m_ffvec  = 2'b00;
    m_ffmask = 6'b000000;
    max_cnt  = sel_b ? 3 : 255;
    foreach (q_vec[i]) begin
      m = q_resp[i] ^ ref_exp(q_vec[i]);
      if (m != 6'd0) begin
        n_err++;
        if (!m_ffv) begin
          m_ffv    = 1'b1;
          m_ffvec  = q_vec[i];
          m_ffmask = m;
        end
      end
      if (int'(q_vec[i]) != i % 4) m_ord = 1'b1;
    end
    if (n_err > max_cnt) n_err = max_cnt;
    chk({tag, ".done"},      sel_b ? done_b : done_a, 1);
    chk({tag, ".busy"},      sel_b ? busy_b : busy_a, 0);
    chk({tag, ".in_ready"},  sel_b ? rdy_b : rdy_a, 0);
    chk({tag, ".err_count"}, sel_b ? 32'(errc_b) : 32'(errc_a), n_err);
    chk({tag, ".order_err"}, sel_b ? ord_b : ord_a, 32'(m_ord));
    chk({tag, ".ff_valid"},  sel_b ? ffv_b : ffv_a, 32'(m_ffv));
    chk({tag, ".ff_vec"},    sel_b ? ffvec_b : ffvec_a, 32'(m_ffvec));
    chk({tag, ".ff_mask"},   sel_b ? ffmask_b : ffmask_a, 32'(m_ffmask));
    chk({tag, ".pass"},      sel_b ? pass_b : pass_a, 32'((n_err == 0) && !m_ord));
  endtask

  initial begin
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    in_valid = 1'b0;
    in_vec   = 2'b00;
    in_resp  = 6'h00;
    tick();
    tick();
    reset = 1'b0;

    chk("reset.in_ready", rdy_a, 0);
    chk("reset.busy", busy_a, 0);
    chk("reset.done", done_a, 0);
    chk("reset.pass", pass_a, 0);
    chk("reset.err_count", errc_a, 0);
    chk("reset.order_err", ord_a, 0);
    chk("reset.ff_valid", ffv_a, 0);
    chk("reset.ff_vec", ffvec_a, 0);
    chk("reset.ff_mask", ffmask_a, 0);

    // Beats offered while idle must be ignored.
    beat(2'd1, 6'h3F);
    beat(2'd2, 6'h00);
    chk("idle.busy", busy_a, 0);
    chk("idle.err_count", errc_a, 0);

    // Golden-function anchors for known vectors.
    chk("golden.vec0", ref_exp(2'd0), 6'h38);
    chk("golden.vec3", ref_exp(2'd3), 6'h23);

    // Clean in-order run.
    start_run(1'b0);
    for (int i = 0; i < 3; i++) beat(2'(i), ref_exp(2'(i)));
    chk("clean.not_done_yet", done_a, 0);
    beat(2'd3, ref_exp(2'd3));
    check_run("clean", 1'b0);
    beat(2'd0, 6'h00);
    chk("done_hold.done", done_a, 1);
    chk("done_hold.err_count", errc_a, 0);
    q_vec.delete();
    q_resp.delete();

    // Stuck-at-1 on the AND output for vec 2.
    start_run(1'b0);
    for (int i = 0; i < 4; i++) beat(2'(i), (i == 2) ? (ref_exp(2'(i)) | 6'h01) : ref_exp(2'(i)));
    check_run("and_stuck1", 1'b0);
    chk("and_stuck1.mask_literal", ffmask_a, 6'h01);

    // Stuck-at-0 on XNOR: vec0 and vec3 both fail, first capture kept.
    start_run(1'b0);
    beat(2'd0, 6'h18);
    beat(2'd1, ref_exp(2'd1));
    beat(2'd2, ref_exp(2'd2));
    beat(2'd3, 6'h03);
    check_run("xnor_stuck0", 1'b0);
    chk("xnor_stuck0.count_literal", errc_a, 2);
    chk("xnor_stuck0.mask_literal", ffmask_a, 6'h20);

    // Correct responses, wrong order.
    start_run(1'b0);
    beat(2'd0, ref_exp(2'd0));
    beat(2'd2, ref_exp(2'd2));
    beat(2'd1, ref_exp(2'd1));
    beat(2'd3, ref_exp(2'd3));
    check_run("order", 1'b0);

    // Toggling valid, reset after two acceptances, then a fresh full run.
    start_run(1'b0);
    beat(2'd0, 6'h00);
    gap();
    beat(2'd1, 6'h00);
    gap();
    in_valid = 1'b1;
    in_vec   = 2'd2;
    in_resp  = 6'h00;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("midreset.busy", busy_a, 0);
    chk("midreset.in_ready", rdy_a, 0);
    chk("midreset.err_count", errc_a, 0);
    chk("midreset.ff_valid", ffv_a, 0);
    start_run(1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("midreset.not_done_yet", done_a, 0);
      beat(2'(i), ref_exp(2'(i)));
      gap();
    end
    q_vec.delete();
    q_resp.delete();
    for (int i = 0; i < 4; i++) begin
      q_vec.push_back(2'(i));
      q_resp.push_back(ref_exp(2'(i)));
    end
    chk("midreset.done_held", done_a, 1);
    chk("midreset.pass", pass_a, 1);

    // Start held high through a run re-launches right after DONE.
    start_a = 1'b1;
    tick();
    q_vec.delete();
    q_resp.delete();
    beat(2'd0, 6'h00);
    for (int i = 1; i < 4; i++) beat(2'(i), ref_exp(2'(i)));
    check_run("start_held", 1'b0);
    in_valid = 1'b0;
    tick();
    start_a = 1'b0;
    chk("start_held.done_pulse", done_a, 0);
    chk("start_held.relaunch_busy", busy_a, 1);
    chk("start_held.err_cleared", errc_a, 0);
    chk("start_held.ff_cleared", ffv_a, 0);
    q_vec.delete();
    q_resp.delete();
    for (int i = 0; i < 4; i++) beat(2'(i), ref_exp(2'(i)));
    check_run("start_held.second", 1'b0);

    // Randomized runs with gaps, order slips and injected faults.
    for (int r = 0; r < 12; r++) begin
      int         acc;
      logic [1:0] v;
      logic [5:0] rs;
      start_run(1'b0);
      acc = 0;
      while (acc < 4) begin
        if ($urandom_range(0, 2) == 0) begin
          gap();
        end else begin
          v  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(acc % 4);
          rs = ref_exp(v);
          if ($urandom_range(0, 2) == 0) rs = rs ^ 6'($urandom_range(1, 63));
          beat(v, rs);
          acc++;
        end
      end
      check_run($sformatf("rand%0d", r), 1'b0);
      in_valid = 1'b0;
    end

    // Narrow counter instance: every response wrong, count saturates.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_run(1'b1);
    for (int i = 0; i < 6; i++) beat(2'(i % 4), ~ref_exp(2'(i % 4)));
    in_valid = 1'b0;
    check_run("saturate", 1'b1);
    chk("saturate.count_literal", errc_b, 2'd3);
    chk("saturate.mask_literal", ffmask_b, 6'h3F);
    chk("saturate.other_idle", busy_a, 0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("saturate.restart_err", errc_b, 0);
    chk("saturate.restart_done", done_b, 0);
    chk("saturate.restart_ff", ffv_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
